assoc_cache_ctrl: RTL and testbench

//  N-way set-associative, write-through, read-allocate data cache controller between EXE_Stage_Reg and SRAM_Controller.

---
 rtl/assoc_cache_ctrl_if.sv | 30 +++
 rtl/assoc_cache_ctrl.sv | 160 ++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_ctrl_if.sv
// Bundles the pipeline-side request signals and the SRAM-side line port of the
// set-associative cache controller; the cache is the slave of this bundle.
interface assoc_cache_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [31:0]       rdata;
    logic              ready;

    logic [ADDR_W-1:0] sram_address;
    logic [31:0]       sram_wdata;
    logic              sram_read;
    logic              sram_write;
    logic [63:0]       sram_rdata;
    logic              sram_ready;

    // The environment: EXE stage on the request side, SRAM controller on the line side.
    modport master (
        output address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write
    );

    modport slave (
        input  address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_read, sram_write
    );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative, write-through, read-allocate data cache controller with
// per-set round-robin replacement and read hit/miss counters.
module assoc_cache_ctrl #(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    assoc_cache_ctrl_if.slave    bus,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - 3 - IDX_W;

    typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_e;

    state_e              state_q, state_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic                valid_q  [WAYS][SETS];
    logic [TAG_W-1:0]    tag_q    [WAYS][SETS];
    logic [63:0]         line_q   [WAYS][SETS];
    logic [WAY_W-1:0]    victim_q [SETS];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                word_sel;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [63:0]         hit_line;
    logic [63:0]         upd_line;
    logic [WAY_W-1:0]    fill_way;
    logic                fill_en;
    logic                upd_en;

    logic [31:0]         rdata;
    logic                ready;
    logic                sram_read;
    logic                sram_write;

    logic                unused_addr_bits;

    assign idx      = bus.address[3 +: IDX_W];
    assign tag      = bus.address[ADDR_W-1 -: TAG_W];
    assign word_sel = bus.address[2];
    assign fill_way = victim_q[idx];
    assign unused_addr_bits = &{1'b0, bus.address[1:0]};

    // Tag lookup across all ways of the addressed set; at most one way can match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line = line_q[hit_way][idx];
    assign upd_line = word_sel ? {bus.wdata, hit_line[31:0]} : {hit_line[63:32], bus.wdata};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        ready      = 1'b0;
        rdata      = '0;
        sram_read  = 1'b0;
        sram_write = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_w_en) begin
                    sram_write = 1'b1;
                    upd_en     = hit;
                    state_d    = WRITE;
                end else if (bus.mem_r_en) begin
                    if (hit) begin
                        ready     = 1'b1;
                        rdata     = word_sel ? hit_line[63:32] : hit_line[31:0];
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end else begin
                        sram_read  = 1'b1;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        state_d    = RMISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            RMISS: begin
                sram_read = 1'b1;
                if (bus.sram_ready) begin
                    ready   = 1'b1;
                    rdata   = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                sram_write = 1'b1;
                if (bus.sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                victim_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (fill_en) begin
                valid_q[fill_way][idx] <= 1'b1;
                victim_q[idx]          <= victim_q[idx] + WAY_W'(1);
            end
        end
    end

    // NOTE: tag and data arrays are not reset; valid bits alone decide whether their contents matter.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_way][idx]  <= tag;
            line_q[fill_way][idx] <= bus.sram_rdata;
        end else if (upd_en) begin
            line_q[hit_way][idx]  <= upd_line;
        end
    end

    assign bus.rdata        = rdata;
    assign bus.ready        = ready;
    assign bus.sram_read    = sram_read;
    assign bus.sram_write   = sram_write;
    assign bus.sram_address = bus.address;
    assign bus.sram_wdata   = bus.wdata;
    assign hit_cnt          = hit_cnt_q;
    assign miss_cnt         = miss_cnt_q;
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Self-checking bench for assoc_cache_ctrl (WAYS=2, SETS=64): table of requests
// plus hand-written reset-abort and simultaneous read/write sequences.
module tb_assoc_cache_ctrl;
    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          lat;
        logic        sram_rd;
        logic        sram_wr;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    assoc_cache_ctrl_if #(.ADDR_W(32)) bus ();

    assoc_cache_ctrl #(.WAYS(2), .SETS(64), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    // SRAM model: line store with sram_ready pulsed 4 cycles after a request starts.
    logic [63:0] sram_mem [512];
    int          sram_cnt;

    assign bus.sram_rdata = sram_mem[bus.sram_address[11:3]];

    always @(posedge clk) begin
        if (rst) begin
            bus.sram_ready <= 1'b0;
            sram_cnt       <= 0;
            for (int i = 0; i < 512; i++) sram_mem[i] <= 64'h0;
            sram_mem[9'h080] <= 64'h0000BBBB_0000AAAA;
            sram_mem[9'h0C0] <= 64'h00006661_00006660;
            sram_mem[9'h100] <= 64'h00008881_00008880;
            sram_mem[9'h140] <= 64'h0000A0A1_0000A0A0;
        end else begin
            bus.sram_ready <= 1'b0;
            if ((bus.sram_read || bus.sram_write) && !bus.sram_ready) begin
                if (sram_cnt == 3) begin
                    bus.sram_ready <= 1'b1;
                    sram_cnt       <= 0;
                    if (bus.sram_write) begin
                        if (bus.sram_address[2])
                            sram_mem[bus.sram_address[11:3]][63:32] <= bus.sram_wdata;
                        else
                            sram_mem[bus.sram_address[11:3]][31:0]  <= bus.sram_wdata;
                    end
                end else begin
                    sram_cnt <= sram_cnt + 1;
                end
            end else begin
                sram_cnt <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int lat,
                                input logic sram_rd, input logic sram_wr,
                                input logic [31:0] hits, input logic [31:0] misses);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.e.name = name; v.e.rdata = rdata; v.e.lat = lat;
        v.e.sram_rd = sram_rd; v.e.sram_wr = sram_wr;
        v.e.hits = hits; v.e.misses = misses;
        return v;
    endfunction

    // Drive one request, push its expectation, wait (bounded) for ready, pop and compare.
    task automatic run_req(input vec_t v);
        exp_t e;
        int   lat = 0;
        logic saw_rd = 1'b0;
        logic saw_wr = 1'b0;
        bit   done = 1'b0;
        sb_q.push_back(v.e);
        @(negedge clk);
        bus.address  = v.addr;
        bus.wdata    = v.wdata;
        bus.mem_r_en = v.rd;
        bus.mem_w_en = v.wr;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            saw_rd |= bus.sram_read;
            saw_wr |= bus.sram_write;
            if (bus.ready) begin
                e = sb_q.pop_front();
                if (v.rd && !v.wr) check({e.name, " rdata"}, 64'(bus.rdata), 64'(e.rdata));
                check({e.name, " ready latency"}, 64'(lat), 64'(e.lat));
                check({e.name, " sram_read seen"}, 64'(saw_rd), 64'(e.sram_rd));
                check({e.name, " sram_write seen"}, 64'(saw_wr), 64'(e.sram_wr));
                done = 1'b1;
            end else begin
                lat++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: ready still 0 after 20 cycles, required 1", v.e.name);
            e = sb_q.pop_front();
        end
        @(negedge clk);
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        #1;
        check({v.e.name, " hit_cnt"}, 64'(hit_cnt), 64'(v.e.hits));
        check({v.e.name, " miss_cnt"}, 64'(miss_cnt), 64'(v.e.misses));
        check({v.e.name, " idle ready"}, 64'(bus.ready), 64'd1);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk("rd 400 cold",     1, 0, 32'h400, 32'h0,    32'hAAAA, 4, 1, 0, 0, 1);
        vecs[1]  = mk("rd 400 rehit",    1, 0, 32'h400, 32'h0,    32'hAAAA, 0, 0, 0, 1, 1);
        vecs[2]  = mk("rd 404 hit",      1, 0, 32'h404, 32'h0,    32'hBBBB, 0, 0, 0, 2, 1);
        vecs[3]  = mk("rd 600 fill w1",  1, 0, 32'h600, 32'h0,    32'h6660, 4, 1, 0, 2, 2);
        vecs[4]  = mk("rd 800 evict w0", 1, 0, 32'h800, 32'h0,    32'h8880, 4, 1, 0, 2, 3);
        vecs[5]  = mk("rd 600 hit",      1, 0, 32'h600, 32'h0,    32'h6660, 0, 0, 0, 3, 3);
        vecs[6]  = mk("rd 400 evicted",  1, 0, 32'h400, 32'h0,    32'hAAAA, 4, 1, 0, 3, 4);
        vecs[7]  = mk("wr 404 cached",   0, 1, 32'h404, 32'h1234, 32'h0,    4, 0, 1, 3, 4);
        vecs[8]  = mk("rd 404 updated",  1, 0, 32'h404, 32'h0,    32'h1234, 0, 0, 0, 4, 4);
        vecs[9]  = mk("wr A00 uncached", 0, 1, 32'hA00, 32'h5555, 32'h0,    4, 0, 1, 4, 4);
        vecs[10] = mk("rd A00 no alloc", 1, 0, 32'hA00, 32'h0,    32'h5555, 4, 1, 0, 4, 5);
        vecs[11] = mk("rd A04 hit",      1, 0, 32'hA04, 32'h0,    32'hA0A1, 0, 0, 0, 5, 5);
        vecs[12] = mk("rd 400 way1 hit", 1, 0, 32'h400, 32'h0,    32'hAAAA, 0, 0, 0, 6, 5);

        bus.address  = '0;
        bus.wdata    = '0;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset ready", 64'(bus.ready), 64'd1);
        check("reset rdata", 64'(bus.rdata), 64'd0);
        check("reset sram_read", 64'(bus.sram_read), 64'd0);
        check("reset sram_write", 64'(bus.sram_write), 64'd0);
        check("reset hit_cnt", 64'(hit_cnt), 64'd0);
        check("reset miss_cnt", 64'(miss_cnt), 64'd0);

        for (int i = 0; i < 13; i++) run_req(vecs[i]);

        // Reset abort on the second RMISS cycle of a read miss to 0x800.
        @(negedge clk);
        bus.address  = 32'h800;
        bus.mem_r_en = 1'b1;
        #1;
        check("abort miss sram_read", 64'(bus.sram_read), 64'd1);
        check("abort miss ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.mem_r_en = 1'b0;
        #1;
        check("abort sram_read", 64'(bus.sram_read), 64'd0);
        check("abort ready", 64'(bus.ready), 64'd1);
        check("abort hit_cnt", 64'(hit_cnt), 64'd0);
        check("abort miss_cnt", 64'(miss_cnt), 64'd0);

        run_req(mk("post-rst rd 400", 1, 0, 32'h400, 32'h0,    32'hAAAA, 4, 1, 0, 0, 1));
        run_req(mk("rd+wr 400",       1, 1, 32'h400, 32'h7777, 32'h0,    4, 0, 1, 0, 1));
        run_req(mk("rd 400 after rw", 1, 0, 32'h400, 32'h0,    32'h7777, 0, 0, 0, 1, 1));
        run_req(mk("rd 404 word1",    1, 0, 32'h404, 32'h0,    32'hBBBB, 0, 0, 0, 2, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
